// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: button conditioning, tick prescaler, counter clear and lap display mux.
// Optional button debounce is built when STOPWATCH_DEBOUNCE_EN is defined.
module stopwatch_controller #(
  parameter int unsigned c_TICK_DIV  = 1000000,
  parameter int unsigned c_DB_CYCLES = 250000
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_START_STOP,
  input  logic       i_LAP,
  input  logic       i_CLEAR,
  input  logic [3:0] i_Digit_1_val,
  input  logic [3:0] i_Digit_2_val,
  input  logic [3:0] i_Digit_3_val,
  input  logic [3:0] i_Digit_4_val,
  output logic       o_CLK_EN,
  output logic       o_CNT_RST,
  output logic [3:0] o_Disp_1_val,
  output logic [3:0] o_Disp_2_val,
  output logic [3:0] o_Disp_3_val,
  output logic [3:0] o_Disp_4_val,
  output logic       o_RUNNING,
  output logic       o_LAP_ACTIVE
);

  localparam int unsigned PrescW = (c_TICK_DIV > 2) ? $clog2(c_TICK_DIV) : 1;

  if (c_TICK_DIV < 2 || c_DB_CYCLES < 1) begin : g_param_check
    $error("stopwatch_controller: c_TICK_DIV must be >= 2 and c_DB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {StIdle, StRunning, StLap, StPaused} state_e;

  state_e              state_q, state_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic                clk_en_q, clk_en_d;
  logic                cnt_rst_q, cnt_rst_d;
  logic                running_q, running_d;
  logic                lap_active_q, lap_active_d;
  logic [15:0]         lap_q, lap_d;
  // Button vectors are ordered {clear, start_stop, lap}.
  logic [2:0]          sync1_q, sync2_q, hist_q, hist_d, evt_q, evt_d;
  logic [2:0]          level;
  logic                ev_clr, ev_ss, ev_lap;
  logic [15:0]         digits;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int unsigned DbW = (c_DB_CYCLES > 1) ? $clog2(c_DB_CYCLES) : 1;
  logic [2:0]     db_q, db_d;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbW'(c_DB_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign level = db_q;
`else
  assign level = sync2_q;
`endif

  assign digits = {i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val};
  assign ev_clr = evt_q[2];
  assign ev_ss  = evt_q[1] & ~evt_q[2];
  assign ev_lap = evt_q[0] & ~evt_q[1] & ~evt_q[2];

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    clk_en_d  = 1'b0;
    cnt_rst_d = 1'b0;
    lap_d     = lap_q;
    hist_d    = level;
    evt_d     = level & ~hist_q;

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        if (ev_clr) begin
          cnt_rst_d = 1'b1;
        end else if (ev_ss) begin
          state_d = StRunning;
        end
      end
      StRunning, StLap: begin
        if (ev_clr) begin
          state_d   = StIdle;
          presc_d   = '0;
          cnt_rst_d = 1'b1;
        end else if (ev_ss) begin
          // Pause freezes the prescaler phase and suppresses any tick due this edge.
          state_d = StPaused;
        end else begin
          if (ev_lap) begin
            if (state_q == StRunning) begin
              state_d = StLap;
              lap_d   = digits;
            end else begin
              state_d = StRunning;
            end
          end
          if (presc_q == PrescW'(c_TICK_DIV - 1)) begin
            presc_d  = '0;
            clk_en_d = 1'b1;
          end else begin
            presc_d = presc_q + PrescW'(1);
          end
        end
      end
      StPaused: begin
        if (ev_clr) begin
          state_d   = StIdle;
          presc_d   = '0;
          cnt_rst_d = 1'b1;
        end else if (ev_ss) begin
          state_d = StRunning;
        end
      end
      default: state_d = StIdle;
    endcase

    running_d    = (state_d == StRunning) || (state_d == StLap);
    lap_active_d = (state_d == StLap);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      clk_en_q     <= 1'b0;
      cnt_rst_q    <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      lap_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      hist_q       <= '0;
      evt_q        <= '0;
`ifdef STOPWATCH_DEBOUNCE_EN
      db_q         <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      clk_en_q     <= clk_en_d;
      cnt_rst_q    <= cnt_rst_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      lap_q        <= lap_d;
      sync1_q      <= {i_CLEAR, i_START_STOP, i_LAP};
      sync2_q      <= sync1_q;
      hist_q       <= hist_d;
      evt_q        <= evt_d;
`ifdef STOPWATCH_DEBOUNCE_EN
      db_q         <= db_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
`endif
    end
  end

  assign o_CLK_EN     = clk_en_q;
  assign o_CNT_RST    = cnt_rst_q;
  assign o_RUNNING    = running_q;
  assign o_LAP_ACTIVE = lap_active_q;
  assign o_Disp_1_val = lap_active_q ? lap_q[15:12] : i_Digit_1_val;
  assign o_Disp_2_val = lap_active_q ? lap_q[11:8]  : i_Digit_2_val;
  assign o_Disp_3_val = lap_active_q ? lap_q[7:4]   : i_Digit_3_val;
  assign o_Disp_4_val = lap_active_q ? lap_q[3:0]   : i_Digit_4_val;

endmodule
